// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: PC, internal imem, DEPTH-entry prefetch buffer, valid/ready to decode.
// Optional perf counters (fetch_cnt, stall_cnt) enabled by defining IFU_PERF_CNT_EN.
module ifu_prefetch #(
  parameter int IW       = 16,
  parameter int AW       = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       imem_we,
  input  logic [AW-1:0]              imem_waddr,
  input  logic [IW-1:0]              imem_wdata,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic [IW-1:0]              isr,
  output logic [AW-1:0]              isr_pc,
  output logic                       isr_valid,
  input  logic                       isr_ready,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [31:0]                fetch_cnt,
  output logic [31:0]                stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] r_imem    [0:(1<<AW)-1];
  logic [IW-1:0] r_buf_ins [0:DEPTH-1];
  logic [AW-1:0] r_buf_pc  [0:DEPTH-1];

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_pc;

  logic          w_valid, w_full, w_pop, w_push;
  logic [IW-1:0] w_fetch;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // Redirect wins over both sides of the buffer; a full buffer still fetches when the head pops.
  assign w_pop   = w_valid & isr_ready & ~redirect;
  assign w_push  = en & ~redirect & (~w_full | w_pop);
  assign w_fetch = r_imem[r_pc];

  // Program-load port; the same-edge fetch sees the pre-write word.
  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_ins[r_tail] <= w_fetch;
      r_buf_pc[r_tail]  <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= AW'(RESET_PC);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
        r_pc   <= r_pc + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are masked to zero while the buffer is empty.
  assign isr        = w_valid ? r_buf_ins[r_head] : '0;
  assign isr_pc     = w_valid ? r_buf_pc[r_head]  : '0;
  assign isr_valid  = w_valid;
  assign pc         = r_pc;
  assign fifo_count = r_count;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push)                r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_valid & ~isr_ready)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: vector table, directed corner sequences, random run against a queue model.
module tb_ifu_prefetch;
  localparam int IW = 16, AW = 8, DEPTH = 4;

  logic          clk = 1'b0, reset = 1'b0;
  logic          en = 1'b0, imem_we = 1'b0, redirect = 1'b0, isr_ready = 1'b0;
  logic [AW-1:0] imem_waddr = '0, redirect_pc = '0;
  logic [IW-1:0] imem_wdata = '0;
  logic [IW-1:0] isr;
  logic [AW-1:0] isr_pc, pc;
  logic          isr_valid;
  logic [2:0]    fifo_count;
  logic [31:0]   fetch_cnt, stall_cnt;

  ifu_prefetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .en(en), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .isr(isr), .isr_pc(isr_pc), .isr_valid(isr_valid), .isr_ready(isr_ready),
    .pc(pc), .fifo_count(fifo_count), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: a queue of {word, pc}, a shadow imem and a fetch address.
  typedef struct { logic [15:0] d; logic [7:0] p; } ent_t;
  ent_t        mq[$];
  logic [15:0] mimem [256];
  logic [7:0]  mpc;
  int unsigned mfetch, mstall;

  typedef struct {
    bit rst; bit en; bit rdy;
    bit [15:0] isr; bit [7:0] ipc; bit vld; bit [7:0] pc; bit [2:0] cnt;
  } vec_t;
  vec_t tv[20];

  function automatic vec_t mk(bit r, bit e, bit rd, int i, int ip, bit v, int p, int c);
    vec_t t;
    t.rst = r; t.en = e; t.rdy = rd; t.isr = 16'(i); t.ipc = 8'(ip);
    t.vld = v; t.pc = 8'(p); t.cnt = 3'(c);
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_fetch();
`ifdef IFU_PERF_CNT_EN
    return mfetch;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef IFU_PERF_CNT_EN
    return mstall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic compare_model();
    bit ne;
    ne = (mq.size() != 0);
    check("model_valid", 32'(isr_valid), 32'(ne));
    check("model_isr",   32'(isr),       ne ? 32'(mq[0].d) : 32'd0);
    check("model_isrpc", 32'(isr_pc),    ne ? 32'(mq[0].p) : 32'd0);
    check("model_pc",    32'(pc),        32'(mpc));
    check("model_count", 32'(fifo_count), 32'(mq.size()));
    check("model_fetch", fetch_cnt, exp_fetch());
    check("model_stall", stall_cnt, exp_stall());
  endtask

  task automatic model_edge();
    bit   pp, ps;
    ent_t e;
    if (mq.size() != 0 && !isr_ready) mstall++;
    if (redirect) begin
      mq.delete();
      mpc = redirect_pc;
    end else begin
      pp = (mq.size() != 0) && isr_ready;
      ps = en && ((mq.size() < DEPTH) || pp);
      e.d = mimem[mpc];
      e.p = mpc;
      if (pp) void'(mq.pop_front());
      if (ps) begin mq.push_back(e); mpc++; mfetch++; end
    end
    if (imem_we) mimem[imem_waddr] = imem_wdata;
  endtask

  // Called at a negedge: drive, clock once, update model, compare at the next negedge.
  task automatic step(input bit e, input bit r, input bit rd, input bit [7:0] rp,
                      input bit we, input bit [7:0] wa, input bit [15:0] wd);
    en = e; isr_ready = r; redirect = rd; redirect_pc = rp;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic run(input bit e, input bit r);
    step(e, r, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0);
  endtask

  // Asserts reset dly after a negedge (clear of any rising edge) and checks it acts at once.
  task automatic do_reset(input int dly);
    #(dly);
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(isr_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_isr",   32'(isr), 32'd0);
    check("rst_isrpc", 32'(isr_pc), 32'd0);
    check("rst_pc",    32'(pc), 32'd0);
    check("rst_fetch", fetch_cnt, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    mq.delete(); mpc = 8'd0; mfetch = 0; mstall = 0;
    en = 1'b0; isr_ready = 1'b0; redirect = 1'b0; imem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int vals[7] = '{3, 7, 15, 31, 64, 128, 255};

    for (int i = 0; i < 7; i++) tv[i] = mk(0, 1, 1, vals[i], i, 1, i + 1, 1);
    tv[7]  = mk(0, 0, 1, 0,   0, 0, 7, 0);
    tv[8]  = mk(1, 1, 0, 3,   0, 1, 1, 1);
    tv[9]  = mk(0, 1, 0, 3,   0, 1, 2, 2);
    tv[10] = mk(0, 1, 0, 3,   0, 1, 3, 3);
    tv[11] = mk(0, 1, 0, 3,   0, 1, 4, 4);
    tv[12] = mk(0, 1, 0, 3,   0, 1, 4, 4);
    tv[13] = mk(0, 1, 0, 3,   0, 1, 4, 4);
    tv[14] = mk(0, 1, 1, 7,   1, 1, 5, 4);
    tv[15] = mk(0, 1, 1, 15,  2, 1, 6, 4);
    tv[16] = mk(0, 1, 1, 31,  3, 1, 7, 4);
    tv[17] = mk(0, 1, 1, 64,  4, 1, 8, 4);
    tv[18] = mk(0, 1, 1, 128, 5, 1, 9, 4);
    tv[19] = mk(0, 0, 1, 255, 6, 1, 9, 3);

    #1;
    do_reset(0);

    // Program load: background pattern then the test words.
    for (int a = 0; a < 256; a++)
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'(a), 16'h5A00 ^ 16'(a));
    for (int a = 0; a < 7; a++)
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'(a), 16'(vals[a]));

    // Streaming and backpressure table; imem must survive reset.
    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      if (tv[i].rst) do_reset(0);
      run(tv[i].en, tv[i].rdy);
      check($sformatf("tv%0d_isr", i),   32'(isr),        32'(tv[i].isr));
      check($sformatf("tv%0d_isrpc", i), 32'(isr_pc),     32'(tv[i].ipc));
      check($sformatf("tv%0d_valid", i), 32'(isr_valid),  32'(tv[i].vld));
      check($sformatf("tv%0d_pc", i),    32'(pc),         32'(tv[i].pc));
      check($sformatf("tv%0d_count", i), 32'(fifo_count), 32'(tv[i].cnt));
`ifdef IFU_PERF_CNT_EN
      if (i == 13) check("tv_stall5", stall_cnt, 32'd5);
`endif
    end

    // Flush from full, then fetch from the redirect target.
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    step(1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 8'd0, 16'd0);
    check("redir_valid", 32'(isr_valid), 32'd0);
    check("redir_count", 32'(fifo_count), 32'd0);
    check("redir_pc",    32'(pc), 32'd5);
    run(1'b1, 1'b1);
    check("redir_isr",   32'(isr), 32'd128);
    check("redir_isrpc", 32'(isr_pc), 32'd5);
    check("redir_pc2",   32'(pc), 32'd6);

    // PC wrap 255 -> 0.
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd255, 16'hAAAA);
    step(1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 8'd0, 16'd0);
    run(1'b1, 1'b1);
    check("wrap_isr0", 32'(isr), 32'hAAAA);
    check("wrap_pc0",  32'(isr_pc), 32'd255);
    run(1'b1, 1'b1);
    check("wrap_isr1", 32'(isr), 32'd3);
    check("wrap_pc1",  32'(isr_pc), 32'd0);
    run(1'b1, 1'b1);
    check("wrap_isr2", 32'(isr), 32'd7);
    check("wrap_pc2",  32'(isr_pc), 32'd1);

    // Drain with en=0: three pops, pc frozen.
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 16'd0);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1'b1);
      check($sformatf("drain%0d_pc", i),    32'(pc), 32'd3);
      check($sformatf("drain%0d_count", i), 32'(fifo_count), 32'(2 - i));
    end
    check("drain_valid", 32'(isr_valid), 32'd0);

    // Write and fetch of the same address on one edge: old word is fetched.
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd3, 16'h1234);
    check("rw_old", 32'(isr), 32'd31);
    step(1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 8'd0, 16'd0);
    run(1'b1, 1'b1);
    check("rw_new", 32'(isr), 32'h1234);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(1'(($urandom % 10) < 8), 1'(($urandom % 10) < 6), 1'(($urandom % 20) == 0),
           8'($urandom), 1'(($urandom % 10) == 0), 8'($urandom), 16'($urandom));

    // Asynchronous reset mid-stream, then resume from RESET_PC.
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0);
    do_reset(2);
    run(1'b1, 1'b1);
    check("resume_isrpc", 32'(isr_pc), 32'd0);
    check("resume_isr",   32'(isr), 32'(mimem[0]));
    for (int i = 0; i < 5; i++) run(1'b1, 1'($urandom % 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit; successor to the single-word IFU. Holds the PC and an internal instruction memory, and prefetches into a DEPTH-entry buffer. Delivers instructions to decode over a valid/ready handshake, with branch redirect/flush. Sits between the instruction memory and the decode stage.

Parameters:
IW, 16, instruction width in bits
AW, 8, PC/imem address width; imem has 2^AW words
DEPTH, 4, prefetch buffer entries; power of 2, >=2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  fetch enable
imem_we  input  1  imem write strobe (program load)
imem_waddr  input  AW  imem write address
imem_wdata  input  IW  imem write data
redirect  input  1  branch redirect/flush request
redirect_pc  input  AW  redirect target
isr  output  IW  instruction at buffer head
isr_pc  output  AW  PC of the isr word
isr_valid  output  1  head entry valid
isr_ready  input  1  decode accepts head
pc  output  AW  next fetch address
fifo_count  output  $clog2(DEPTH)+1  occupied entries
fetch_cnt  output  32  perf: words pushed
stall_cnt  output  32  perf: backpressure cycles

Behaviour:
- Reset (async, immediate, no clock needed): pc=RESET_PC, fifo_count=0, isr_valid=0, isr=0, isr_pc=0, fetch_cnt=0, stall_cnt=0. imem contents not reset.
- Read of imem[pc] is combinational. Push condition: en & !redirect & (fifo_count<DEPTH | pop). Push stores {imem[pc], pc} at tail; pc<=pc+1 modulo 2^AW (255 -> 0 at AW=8).
- pop = isr_valid & isr_ready. Pop removes head on the clock edge.
- isr_valid = (fifo_count!=0). When empty, isr=0 and isr_pc=0.
- Push and pop in the same cycle: count unchanged; legal when full, i.e. full + ready still fetches.
- Latency: with en=1, the first edge after reset release pushes imem[RESET_PC]; isr_valid=1 after that edge. Steady-state throughput is 1 word/cycle.
- redirect=1 on an edge: buffer flushed (fifo_count=0, isr_valid=0 after edge), pc<=redirect_pc, no push, pop ignored. Overrides en and isr_ready. Fetch from redirect_pc starts on the next edge.
- en=0: no pushes, pc frozen, buffer drains via pops.
- imem write: imem[imem_waddr]<=imem_wdata on the edge. A same-cycle fetch of the same address returns the old data.
- Head/tail pointers are $clog2(DEPTH) bits and wrap naturally. fifo_count never exceeds DEPTH or underflows.
- Outputs are driven from registers or buffer storage only; no combinational path from isr_ready to isr_valid.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: fetch_cnt +1 per push; stall_cnt +1 per cycle with isr_valid & !isr_ready. Both 32-bit wrapping, cleared by reset, not cleared by redirect.
- Undefined: counters not synthesised; fetch_cnt and stall_cnt tied to 0. Ports remain.

Test Plan:
1. Load imem[0..6]=3,7,15,31,64,128,255; reset 1 then 0; en=1, isr_ready=1 -> isr 3,7,15,31,64,128,255 on consecutive cycles, isr_pc 0..6, isr_valid high from the cycle after the first post-reset edge.
2. Same load, isr_ready=0 -> fifo_count saturates at 4, pc holds at 4, isr holds 3. Raise isr_ready -> 3,7,15,31,64,128 with no loss or duplicate. With IFU_PERF_CNT_EN, stall_cnt equals the number of held-valid cycles.
3. Buffer full (4 entries), pulse redirect with redirect_pc=5 -> next cycle isr_valid=0, fifo_count=0, pc=6 is not yet reached. The following cycle gives isr=128, isr_pc=5.
4. imem[255]=0xAAAA, imem[0]=3; redirect to 255 -> isr_pc sequence 255, 0, 1; isr 0xAAAA, 3, 7.
5. en=0 with 3 entries buffered and isr_ready=1 -> three pops, then isr_valid=0; pc unchanged throughout.
6. Assert reset asynchronously mid-stream (between clock edges) -> isr_valid, fifo_count, and isr drop to 0 and pc=RESET_PC immediately. Fetch resumes from RESET_PC after release.
